branch_predictor_gshare: RTL and testbench

//  Parametrised successor of the 1-bit/32-entry predictor: CNT_W-bit saturating-counter BHT with optional

---
 rtl/branch_predictor_gshare_if.sv | 34 +++
 rtl/branch_predictor_gshare.sv | 107 ++++++++++
 tb/tb_branch_predictor_gshare.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor_gshare_if : IF lookup / EX update / perf bundle           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface branch_predictor_gshare_if #(
  parameter int IDX_W  = 5,
  parameter int PERF_W = 32
);
  logic [31:0]       lookup_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              btb_hit;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispredict;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_miss;

  // master = pipeline side, slave = predictor
  modport master (
    output lookup_pc, upd_valid, upd_idx, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, btb_hit, pred_idx, perf_branches, perf_miss
  );
  modport slave (
    input  lookup_pc, upd_valid, upd_idx, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, btb_hit, pred_idx, perf_branches, perf_miss
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor_gshare : saturating-counter BHT (gshare/bimodal), tagged  |
// | BTB and saturating perf counters. Rev 1.0                                  |
// +----------------------------------------------------------------------------+
module branch_predictor_gshare #(
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 2,
  parameter int GHR_W  = 5,
  parameter int GSHARE = 1,
  parameter int PERF_W = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  branch_predictor_gshare_if.slave  bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]  cnt_q      [ENTRIES];
  logic              btb_vld_q  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q  [ENTRIES];
  logic [31:0]       btb_tgt_q  [ENTRIES];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [PERF_W-1:0] br_q, br_d;
  logic [PERF_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0]  cnt_d;

  logic [IDX_W-1:0]  w_pc_idx;
  logic [IDX_W-1:0]  w_bht_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_upd_btb_idx;
  logic              w_hit;
  logic              w_unused_pc_lsb;

  assign w_pc_idx        = bp.lookup_pc[IDX_W+1:2];
  assign w_tag           = bp.lookup_pc[31:IDX_W+2];
  assign w_upd_btb_idx   = bp.upd_pc[IDX_W+1:2];
  assign w_unused_pc_lsb = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

  // History only steers the BHT; the BTB is always indexed by pc bits.
  generate
    if (GSHARE != 0) begin : g_gshare
      assign w_bht_idx = w_pc_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign w_bht_idx = w_pc_idx;
    end
  endgenerate

  assign w_hit            = btb_vld_q[w_pc_idx] && (btb_tag_q[w_pc_idx] == w_tag);
  assign bp.btb_hit       = w_hit;
  assign bp.pred_taken    = w_hit & cnt_q[w_bht_idx][CNT_W-1];
  assign bp.pred_target   = w_hit ? btb_tgt_q[w_pc_idx] : 32'd0;
  assign bp.pred_idx      = w_bht_idx;
  assign bp.perf_branches = br_q;
  assign bp.perf_miss     = miss_q;

  always_comb begin
    cnt_d  = cnt_q[bp.upd_idx];
    ghr_d  = ghr_q;
    br_d   = br_q;
    miss_d = miss_q;
    if (bp.upd_taken && !(&cnt_d)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end else if (!bp.upd_taken && (|cnt_d)) begin
      cnt_d = cnt_d - CNT_W'(1);
    end
    if (bp.upd_valid) begin
      // Truncating the concatenation also covers the single-bit history case.
      ghr_d = GHR_W'({ghr_q, bp.upd_taken});
      if (!(&br_q)) begin
        br_d = br_q + PERF_W'(1);
      end
      if (bp.upd_mispredict && !(&miss_q)) begin
        miss_d = miss_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]     <= c_cnt_init;
        btb_vld_q[i] <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      ghr_q  <= '0;
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      br_q   <= br_d;
      miss_q <= miss_d;
      if (bp.upd_valid) begin
        cnt_q[bp.upd_idx] <= cnt_d;
        if (bp.upd_taken) begin
          btb_vld_q[w_upd_btb_idx] <= 1'b1;
          btb_tag_q[w_upd_btb_idx] <= bp.upd_pc[31:IDX_W+2];
          btb_tgt_q[w_upd_btb_idx] <= bp.upd_target;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_predictor_gshare : directed vectors with a queued scoreboard      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_branch_predictor_gshare;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  // dut0: bimodal, 32-bit perf; dut1: gshare, 4-bit perf
  branch_predictor_gshare_if #(.IDX_W(5), .PERF_W(32)) bp0 ();
  branch_predictor_gshare_if #(.IDX_W(5), .PERF_W(4))  bp1 ();

  branch_predictor_gshare #(.IDX_W(5), .CNT_W(2), .GHR_W(5), .GSHARE(0), .PERF_W(32)) u_dut0 (
    .clk(clk), .rst(rst0), .bp(bp0.slave));
  branch_predictor_gshare #(.IDX_W(5), .CNT_W(2), .GHR_W(5), .GSHARE(1), .PERF_W(4)) u_dut1 (
    .clk(clk), .rst(rst1), .bp(bp1.slave));

  localparam int F_IDX = 0, F_HIT = 1, F_TKN = 2, F_TGT = 3, F_BR = 4, F_MISS = 5;

  typedef struct {
    int          dut;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input int d, input int f, input logic [31:0] v, input string n);
    exp_t e;
    e.dut = d; e.fld = f; e.val = v; e.name = n;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int d, input int f);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    if (d == 0) begin
      case (f)
        F_IDX:  r = 32'(bp0.pred_idx);
        F_HIT:  r = 32'(bp0.btb_hit);
        F_TKN:  r = 32'(bp0.pred_taken);
        F_TGT:  r = bp0.pred_target;
        F_BR:   r = bp0.perf_branches;
        F_MISS: r = bp0.perf_miss;
        default: r = 32'hDEAD_BEEF;
      endcase
    end else begin
      case (f)
        F_IDX:  r = 32'(bp1.pred_idx);
        F_HIT:  r = 32'(bp1.btb_hit);
        F_TKN:  r = 32'(bp1.pred_taken);
        F_TGT:  r = bp1.pred_target;
        F_BR:   r = 32'(bp1.perf_branches);
        F_MISS: r = 32'(bp1.perf_miss);
        default: r = 32'hDEAD_BEEF;
      endcase
    end
    return r;
  endfunction

  // Monitor: drains every expectation queued for the current cycle on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exp_q.pop_front();
      a = actual(e.dut, e.fld);
      n_tests++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: dut%0d got 0x%08h expected 0x%08h", e.name, e.dut, a, e.val);
      end
    end
  end

  task automatic cyc0(input logic r, input logic v, input logic [4:0] idx, input logic [31:0] pc,
                      input logic t, input logic [31:0] tgt, input logic m, input logic [31:0] lpc);
    @(posedge clk); #1;
    rst0 = r; bp0.upd_valid = v; bp0.upd_idx = idx; bp0.upd_pc = pc;
    bp0.upd_taken = t; bp0.upd_target = tgt; bp0.upd_mispredict = m; bp0.lookup_pc = lpc;
  endtask

  task automatic cyc1(input logic r, input logic v, input logic [4:0] idx, input logic [31:0] pc,
                      input logic t, input logic [31:0] tgt, input logic m, input logic [31:0] lpc);
    @(posedge clk); #1;
    rst1 = r; bp1.upd_valid = v; bp1.upd_idx = idx; bp1.upd_pc = pc;
    bp1.upd_taken = t; bp1.upd_target = tgt; bp1.upd_mispredict = m; bp1.lookup_pc = lpc;
  endtask

  initial begin
    int guard;
    bp0.upd_valid = 1'b0; bp0.upd_idx = '0; bp0.upd_pc = '0; bp0.upd_taken = 1'b0;
    bp0.upd_target = '0; bp0.upd_mispredict = 1'b0; bp0.lookup_pc = '0;
    bp1.upd_valid = 1'b0; bp1.upd_idx = '0; bp1.upd_pc = '0; bp1.upd_taken = 1'b0;
    bp1.upd_target = '0; bp1.upd_mispredict = 1'b0; bp1.lookup_pc = '0;

    // ---- dut0: bimodal ----
    cyc0(1, 0, 0, 0, 0, 0, 0, 32'h3010);
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h3010);
    expect_v(0, F_IDX, 4, "rst_idx");  expect_v(0, F_HIT, 0, "rst_hit");
    expect_v(0, F_TKN, 0, "rst_taken"); expect_v(0, F_TGT, 0, "rst_target");
    expect_v(0, F_BR, 0, "rst_branches"); expect_v(0, F_MISS, 0, "rst_miss");

    cyc0(0, 1, 4, 32'h10, 1, 32'h40, 0, 32'h10);
    expect_v(0, F_TKN, 0, "same_cycle_taken"); expect_v(0, F_HIT, 0, "same_cycle_hit");
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(0, F_HIT, 1, "train_hit"); expect_v(0, F_TKN, 1, "train_taken");
    expect_v(0, F_TGT, 32'h40, "train_target"); expect_v(0, F_BR, 1, "train_branches");

    for (int i = 0; i < 4; i++) cyc0(0, 1, 4, 32'h10, 1, 32'h40, 0, 32'h10);
    cyc0(0, 1, 4, 32'h10, 0, 0, 1, 32'h10);
    expect_v(0, F_TKN, 1, "sat_pre_nt");
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(0, F_TKN, 1, "sat_one_nt");
    cyc0(0, 1, 4, 32'h10, 0, 0, 1, 32'h10);
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(0, F_TKN, 0, "sat_two_nt"); expect_v(0, F_HIT, 1, "nt_keeps_btb");
    expect_v(0, F_TGT, 32'h40, "nt_keeps_target");

    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h90);
    expect_v(0, F_IDX, 4, "alias_idx"); expect_v(0, F_HIT, 0, "alias_hit");
    expect_v(0, F_TKN, 0, "alias_taken"); expect_v(0, F_TGT, 0, "alias_target");

    cyc0(0, 1, 9, 32'h24, 1, 32'h80, 1, 32'h24);
    cyc0(0, 1, 9, 32'h24, 1, 32'h80, 0, 32'h24);
    cyc0(0, 1, 9, 32'h24, 1, 32'h80, 0, 32'h24);
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h24);
    expect_v(0, F_BR, 10, "perf_branches_10"); expect_v(0, F_MISS, 3, "perf_miss_3");
    expect_v(0, F_IDX, 9, "idx9"); expect_v(0, F_TKN, 1, "idx9_taken");
    expect_v(0, F_TGT, 32'h80, "idx9_target");

    // reset wins over a simultaneous update
    cyc0(1, 1, 4, 32'h10, 1, 32'h40, 1, 32'h10);
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(0, F_BR, 0, "rst2_branches"); expect_v(0, F_MISS, 0, "rst2_miss");
    expect_v(0, F_HIT, 0, "rst2_hit"); expect_v(0, F_TKN, 0, "rst2_taken");
    expect_v(0, F_TGT, 0, "rst2_target");
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h24);
    expect_v(0, F_HIT, 0, "rst2_hit24");
    // counter at idx9 must be back at weakly-not-taken: +1 then -1 lands on 1
    cyc0(0, 1, 9, 32'h24, 1, 32'h80, 0, 32'h24);
    cyc0(0, 1, 9, 32'h24, 0, 0, 0, 32'h24);
    expect_v(0, F_TKN, 1, "rst2_ctr_up");
    cyc0(0, 0, 0, 0, 0, 0, 0, 32'h24);
    expect_v(0, F_TKN, 0, "rst2_ctr_down"); expect_v(0, F_HIT, 1, "rst2_rehit");
    expect_v(0, F_BR, 2, "rst2_branches2");

    // ---- dut1: gshare, 4-bit perf ----
    cyc1(1, 0, 0, 0, 0, 0, 0, 32'h10);
    cyc1(0, 1, 4, 32'h10, 1, 32'h40, 0, 32'h10);
    expect_v(1, F_IDX, 4, "gs_idx_ghr0"); expect_v(1, F_BR, 0, "gs_rst_branches");
    cyc1(0, 1, 4, 32'h10, 1, 32'h40, 1, 32'h10);
    expect_v(1, F_IDX, 5, "gs_idx_ghr1"); expect_v(1, F_HIT, 1, "gs_hit1");
    expect_v(1, F_TKN, 0, "gs_taken1");
    cyc1(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(1, F_IDX, 7, "gs_idx_ghr3"); expect_v(1, F_HIT, 1, "gs_btb_pc_idx");
    expect_v(1, F_TGT, 32'h40, "gs_target"); expect_v(1, F_TKN, 0, "gs_taken_idx7");
    expect_v(1, F_BR, 2, "gs_branches2"); expect_v(1, F_MISS, 1, "gs_miss1");

    for (int i = 0; i < 18; i++) cyc1(0, 1, 7, 32'h10, 1, 32'h40, 1, 32'h10);
    cyc1(0, 0, 0, 0, 0, 0, 0, 32'h10);
    expect_v(1, F_IDX, 27, "gs_idx_ghr31"); expect_v(1, F_BR, 15, "gs_branches_sat");
    expect_v(1, F_MISS, 15, "gs_miss_sat"); expect_v(1, F_TKN, 0, "gs_taken_idx27");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
